// File: rtl/image_window_renderer.sv
// image_window_renderer
// Pixel source for the VGA path: places a source image in a runtime-positioned
// window, issues image-memory addresses incrementally (no multiplier), with
// optional 2x pixel/line replication, and returns registered RGB with a
// background colour outside the window. Latency counter -> pixel is 3 cycles.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   count_rgb           horizontal counter (0 = first active pixel)
//   reset_count_rgb     vertical counter (0 = first active line)
//   x0, y0              window top-left corner, sampled at frame start
//   scale               0 = 1x, 1 = 2x replication, sampled at frame start
//   enable              draw image, sampled at frame start
//   bg_colour           {r,g,b} shown outside the window (live)
//   rom_addr            registered image memory address
//   rom_data            {r,g,b} from synchronous memory, one cycle after rom_addr
//   red_1/green_1/blue_1 registered pixel colour
//   in_window           high when the colour outputs carry image data
//   frame_done          pulse when the last image address of a frame is issued
module image_window_renderer #(
  parameter int IMG_W     = 200,
  parameter int IMG_H     = 150,
  parameter int H_BITS    = 11,
  parameter int V_BITS    = 10,
  parameter int ADDR_BITS = 15,
  parameter int CW        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [H_BITS-1:0]    count_rgb,
  input  logic [V_BITS-1:0]    reset_count_rgb,
  input  logic [H_BITS-1:0]    x0,
  input  logic [V_BITS-1:0]    y0,
  input  logic                 scale,
  input  logic                 enable,
  input  logic [3*CW-1:0]      bg_colour,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [3*CW-1:0]      rom_data,
  output logic [CW-1:0]        red_1,
  output logic [CW-1:0]        green_1,
  output logic [CW-1:0]        blue_1,
  output logic                 in_window,
  output logic                 frame_done
);

  localparam logic [H_BITS:0]    IMG_W_H = (H_BITS+1)'(IMG_W);
  localparam logic [V_BITS:0]    IMG_H_V = (V_BITS+1)'(IMG_H);
  localparam logic [H_BITS:0]    ONE_H   = (H_BITS+1)'(1);
  localparam logic [V_BITS:0]    ONE_V   = (V_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] IMG_W_A = ADDR_BITS'(IMG_W);
  localparam logic [ADDR_BITS-1:0] ONE_A   = ADDR_BITS'(1);

  // frame shadows
  logic [H_BITS-1:0]    xs_q, xs_d, xs_e;
  logic [V_BITS-1:0]    ys_q, ys_d, ys_e;
  logic                 ss_q, ss_d, ss_e;
  logic                 es_q, es_d, es_e;
  // address generator state
  logic [ADDR_BITS-1:0] line_base_q, line_base_d, line_base_e;
  logic [ADDR_BITS-1:0] col_q, col_d, col_e;
  logic                 line_phase_q, line_phase_d, line_phase_e;
  logic                 pix_phase_q, pix_phase_d, pix_phase_e;
  // pipeline
  logic [ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                 frame_done_q, frame_done_d;
  logic                 hit_d1_q, hit_d1_d;
  logic                 hit_d2_q, hit_d2_d;
  logic [3*CW-1:0]      rgb_q, rgb_d;
  logic                 in_window_q, in_window_d;

  logic                 fs, col_start, hit, h_last, v_last;
  logic [H_BITS:0]      h_ext, x_lo, x_hi, ww;
  logic [V_BITS:0]      v_ext, y_lo, y_hi, wh;

  always_comb begin
    fs = (count_rgb == '0) && (reset_count_rgb == '0);

    // On the frame-start cycle the freshly sampled config is used immediately,
    // so a window at the origin issues address 0 on that very cycle.
    xs_e         = fs ? x0     : xs_q;
    ys_e         = fs ? y0     : ys_q;
    ss_e         = fs ? scale  : ss_q;
    es_e         = fs ? enable : es_q;
    line_base_e  = fs ? '0     : line_base_q;
    line_phase_e = fs ? 1'b0   : line_phase_q;

    col_start    = (count_rgb == xs_e);
    col_e        = (fs || col_start) ? '0   : col_q;
    pix_phase_e  = (fs || col_start) ? 1'b0 : pix_phase_q;

    // one extra bit so the window end never wraps
    ww    = ss_e ? (IMG_W_H << 1) : IMG_W_H;
    wh    = ss_e ? (IMG_H_V << 1) : IMG_H_V;
    h_ext = {1'b0, count_rgb};
    v_ext = {1'b0, reset_count_rgb};
    x_lo  = {1'b0, xs_e};
    y_lo  = {1'b0, ys_e};
    x_hi  = x_lo + ww;
    y_hi  = y_lo + wh;

    hit    = es_e && (h_ext >= x_lo) && (h_ext < x_hi) &&
             (v_ext >= y_lo) && (v_ext < y_hi);
    h_last = (h_ext + ONE_H) == x_hi;
    v_last = (v_ext + ONE_V) == y_hi;

    xs_d         = xs_e;
    ys_d         = ys_e;
    ss_d         = ss_e;
    es_d         = es_e;
    line_base_d  = line_base_e;
    line_phase_d = line_phase_e;
    col_d        = col_e;
    pix_phase_d  = pix_phase_e;
    rom_addr_d   = rom_addr_q;
    frame_done_d = 1'b0;
    hit_d1_d     = hit;
    hit_d2_d     = hit_d1_q;

    if (hit) begin
      rom_addr_d  = line_base_e + col_e;
      pix_phase_d = ~pix_phase_e;
      // 2x: advance column only on the second copy of each pixel
      if (!ss_e || pix_phase_e) col_d = col_e + ONE_A;
      frame_done_d = h_last && v_last;
      if (h_last) begin
        line_phase_d = ~line_phase_e;
        // 2x: advance row only after its second display line
        if (!ss_e || line_phase_e) line_base_d = line_base_e + IMG_W_A;
      end
    end

    rgb_d       = hit_d2_q ? rom_data : bg_colour;
    in_window_d = hit_d2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q         <= '0;
      ys_q         <= '0;
      ss_q         <= 1'b0;
      es_q         <= 1'b0;
      line_base_q  <= '0;
      line_phase_q <= 1'b0;
      col_q        <= '0;
      pix_phase_q  <= 1'b0;
      rom_addr_q   <= '0;
      frame_done_q <= 1'b0;
      hit_d1_q     <= 1'b0;
      hit_d2_q     <= 1'b0;
      rgb_q        <= '0;
      in_window_q  <= 1'b0;
    end else begin
      xs_q         <= xs_d;
      ys_q         <= ys_d;
      ss_q         <= ss_d;
      es_q         <= es_d;
      line_base_q  <= line_base_d;
      line_phase_q <= line_phase_d;
      col_q        <= col_d;
      pix_phase_q  <= pix_phase_d;
      rom_addr_q   <= rom_addr_d;
      frame_done_q <= frame_done_d;
      hit_d1_q     <= hit_d1_d;
      hit_d2_q     <= hit_d2_d;
      rgb_q        <= rgb_d;
      in_window_q  <= in_window_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign frame_done = frame_done_q;
  assign red_1      = rgb_q[3*CW-1:2*CW];
  assign green_1    = rgb_q[2*CW-1:CW];
  assign blue_1     = rgb_q[CW-1:0];
  assign in_window  = in_window_q;

endmodule

// File: tb/tb_image_window_renderer.sv
// Bench for image_window_renderer with a 4x3 image on a 32x10 raster.
// A behavioural model (window geometry with plain arithmetic) is checked
// against every output on every cycle; literal expectations pin the model.
module tb_image_window_renderer;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int H_TOT = 32;
  localparam int V_TOT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] count_rgb;
  logic [9:0]  reset_count_rgb;
  logic [10:0] x0;
  logic [9:0]  y0;
  logic        scale, enable;
  logic [23:0] bg_colour;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;
  logic [7:0]  red_1, green_1, blue_1;
  logic        in_window, frame_done;

  int checks = 0;
  int errors = 0;

  image_window_renderer #(
    .IMG_W(TW), .IMG_H(TH), .H_BITS(11), .V_BITS(10), .ADDR_BITS(15), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .count_rgb(count_rgb), .reset_count_rgb(reset_count_rgb),
    .x0(x0), .y0(y0), .scale(scale), .enable(enable), .bg_colour(bg_colour),
    .rom_addr(rom_addr), .rom_data(rom_data), .red_1(red_1), .green_1(green_1),
    .blue_1(blue_1), .in_window(in_window), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mem_word(int a);
    return 24'h800000 | 24'(a);
  endfunction

  // synchronous image memory
  always @(posedge clk) rom_data <= mem_word(int'(rom_addr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit hit; int addr; bit last; } look_t;

  function automatic look_t look(int h, int v, int xs, int ys, bit ss, bit es);
    look_t r;
    int sc;
    sc = ss ? 2 : 1;
    r.hit  = es && h >= xs && h < xs + TW*sc && v >= ys && v < ys + TH*sc;
    r.addr = r.hit ? ((v - ys) / sc) * TW + (h - xs) / sc : 0;
    r.last = r.hit && h == xs + TW*sc - 1 && v == ys + TH*sc - 1;
    return r;
  endfunction

  int    m_xs = 0, m_ys = 0;
  bit    m_ss = 0, m_es = 0;
  bit    hp1 = 0, hp2 = 0;
  int    ap1 = 0, ap2 = 0;
  bit    fs_m;
  look_t cur;
  logic [14:0] e_addr = '0;
  logic        e_fd = 1'b0;
  logic [23:0] e_rgb = '0;
  logic        e_inw = 1'b0;
  bit          chk_en = 0;

  always_comb begin
    fs_m = (count_rgb == 11'd0) && (reset_count_rgb == 10'd0);
    cur  = look(int'(count_rgb), int'(reset_count_rgb),
                fs_m ? int'(x0) : m_xs, fs_m ? int'(y0) : m_ys,
                fs_m ? scale : m_ss, fs_m ? enable : m_es);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_xs <= 0; m_ys <= 0; m_ss <= 0; m_es <= 0;
      hp1 <= 0; hp2 <= 0; ap1 <= 0; ap2 <= 0;
      e_addr <= '0; e_fd <= 1'b0; e_rgb <= '0; e_inw <= 1'b0;
      chk_en <= 1;
    end else begin
      if (fs_m) begin
        m_xs <= int'(x0); m_ys <= int'(y0); m_ss <= scale; m_es <= enable;
      end
      e_inw <= hp2;
      e_rgb <= hp2 ? mem_word(ap2) : bg_colour;
      hp2 <= hp1; ap2 <= ap1;
      hp1 <= cur.hit; ap1 <= cur.addr;
      if (cur.hit) e_addr <= 15'(cur.addr);
      e_fd <= cur.last;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", 32'(rom_addr), 32'(e_addr));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("rgb", 32'({red_1, green_1, blue_1}), 32'(e_rgb));
      chk("in_window", 32'(in_window), 32'(e_inw));
    end
  end

  // ---------------- observation by raster position ----------------
  logic [14:0] obs_addr [0:V_TOT-1][0:H_TOT-1];
  logic        obs_fd   [0:V_TOT-1][0:H_TOT-1];
  logic [23:0] obs_pix  [0:V_TOT-1][0:H_TOT-1];
  logic        obs_inw  [0:V_TOT-1][0:H_TOT-1];
  int hd1 = -1, vd1 = 0, hd2 = -1, vd2 = 0;

  // One cycle with the counters already applied; records what each
  // raster position produced (address one edge later, pixel three).
  task automatic tick();
    int h, v;
    h = int'(count_rgb);
    v = int'(reset_count_rgb);
    @(posedge clk);
    #1;
    obs_addr[v][h] = rom_addr;
    obs_fd[v][h]   = frame_done;
    if (hd2 >= 0) begin
      obs_pix[vd2][hd2] = {red_1, green_1, blue_1};
      obs_inw[vd2][hd2] = in_window;
    end
    hd2 = hd1; vd2 = vd1;
    hd1 = h;   vd1 = v;
    if (rst) begin
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_rgb", 32'({red_1, green_1, blue_1}), 32'd0);
      chk("rst_inw", 32'(in_window), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic drive_frame(input int chg_v, input int chg_x, input int rst_v, input int rst_h);
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        count_rgb       = 11'(h);
        reset_count_rgb = 10'(v);
        if (v == chg_v && h == 0) x0 = 11'(chg_x);
        rst = (v == rst_v && h == rst_h);
        tick();
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; count_rgb = 11'd5; reset_count_rgb = 10'd9;
    x0 = '0; y0 = '0; scale = 1'b0; enable = 1'b0; bg_colour = '0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;

    // A: 1x at origin
    enable = 1'b1; bg_colour = 24'h0A0B0C;
    drive_frame(-1, 0, -1, -1);
    chk("A_addr00", 32'(obs_addr[0][0]), 32'd0);
    chk("A_addr03", 32'(obs_addr[0][3]), 32'd3);
    chk("A_addr10", 32'(obs_addr[1][0]), 32'd4);
    chk("A_addr23", 32'(obs_addr[2][3]), 32'd11);
    chk("A_hold05", 32'(obs_addr[0][5]), 32'd3);
    chk("A_fd23", 32'(obs_fd[2][3]), 32'd1);
    chk("A_fd22", 32'(obs_fd[2][2]), 32'd0);
    chk("A_fd13", 32'(obs_fd[1][3]), 32'd0);
    chk("A_pix12", 32'(obs_pix[1][2]), 32'(mem_word(6)));
    chk("A_inw12", 32'(obs_inw[1][2]), 32'd1);
    chk("A_pix04", 32'(obs_pix[0][4]), 32'h0A0B0C);
    chk("A_inw04", 32'(obs_inw[0][4]), 32'd0);

    // B: 2x replication
    scale = 1'b1;
    drive_frame(-1, 0, -1, -1);
    chk("B_addr01", 32'(obs_addr[0][1]), 32'd0);
    chk("B_addr02", 32'(obs_addr[0][2]), 32'd1);
    chk("B_addr17", 32'(obs_addr[1][7]), 32'd3);
    chk("B_addr40", 32'(obs_addr[4][0]), 32'd8);
    chk("B_addr41", 32'(obs_addr[4][1]), 32'd8);
    chk("B_addr57", 32'(obs_addr[5][7]), 32'd11);
    chk("B_fd57", 32'(obs_fd[5][7]), 32'd1);
    chk("B_fd56", 32'(obs_fd[5][6]), 32'd0);
    chk("B_fd47", 32'(obs_fd[4][7]), 32'd0);
    chk("B_pix35", 32'(obs_pix[3][5]), 32'(mem_word(6)));
    chk("B_inw57", 32'(obs_inw[5][7]), 32'd1);
    chk("B_inw08", 32'(obs_inw[0][8]), 32'd0);

    // C: offset window, x0 moved to 20 on line 6 (must not take effect)
    scale = 1'b0; x0 = 11'd10; y0 = 10'd5; bg_colour = 24'h123456;
    drive_frame(6, 20, -1, -1);
    chk("C_pix59", 32'(obs_pix[5][9]), 32'h123456);
    chk("C_inw59", 32'(obs_inw[5][9]), 32'd0);
    chk("C_pix510", 32'(obs_pix[5][10]), 32'(mem_word(0)));
    chk("C_inw510", 32'(obs_inw[5][10]), 32'd1);
    chk("C_pix514", 32'(obs_pix[5][14]), 32'h123456);
    chk("C_inw514", 32'(obs_inw[5][14]), 32'd0);
    chk("C_pix610", 32'(obs_pix[6][10]), 32'(mem_word(4)));
    chk("C_pix713", 32'(obs_pix[7][13]), 32'(mem_word(11)));
    chk("C_inw620", 32'(obs_inw[6][20]), 32'd0);

    // D: next frame picks up x0=20
    drive_frame(-1, 0, -1, -1);
    chk("D_pix520", 32'(obs_pix[5][20]), 32'(mem_word(0)));
    chk("D_inw520", 32'(obs_inw[5][20]), 32'd1);
    chk("D_inw510", 32'(obs_inw[5][10]), 32'd0);
    chk("D_pix723", 32'(obs_pix[7][23]), 32'(mem_word(11)));
    chk("D_fd723", 32'(obs_fd[7][23]), 32'd1);

    // E: reset for one cycle during line 2
    x0 = '0; y0 = '0; bg_colour = 24'h0F0F0F;
    drive_frame(-1, 0, 2, 2);
    chk("E_addr21", 32'(obs_addr[2][1]), 32'd9);
    chk("E_addr22", 32'(obs_addr[2][2]), 32'd0);
    chk("E_addr23", 32'(obs_addr[2][3]), 32'd0);
    chk("E_fd23", 32'(obs_fd[2][3]), 32'd0);
    chk("E_pix13", 32'(obs_pix[1][3]), 32'(mem_word(7)));
    chk("E_pix20", 32'(obs_pix[2][0]), 32'd0);
    chk("E_pix21", 32'(obs_pix[2][1]), 32'h0F0F0F);
    chk("E_pix23", 32'(obs_pix[2][3]), 32'h0F0F0F);
    chk("E_inw23", 32'(obs_inw[2][3]), 32'd0);

    // F: first frame after reset restarts at address 0
    drive_frame(-1, 0, -1, -1);
    chk("F_addr00", 32'(obs_addr[0][0]), 32'd0);
    chk("F_addr01", 32'(obs_addr[0][1]), 32'd1);
    chk("F_pix00", 32'(obs_pix[0][0]), 32'(mem_word(0)));
    chk("F_fd23", 32'(obs_fd[2][3]), 32'd1);

    // G: enable=0 -> background only, address frozen
    enable = 1'b0;
    drive_frame(-1, 0, -1, -1);
    chk("G_addr00", 32'(obs_addr[0][0]), 32'd11);
    chk("G_addr23", 32'(obs_addr[2][3]), 32'd11);
    chk("G_fd23", 32'(obs_fd[2][3]), 32'd0);
    chk("G_inw00", 32'(obs_inw[0][0]), 32'd0);
    chk("G_pix11", 32'(obs_pix[1][1]), 32'h0F0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
